// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage: FSM state codes and
// the default halt encoding / reset PC.
package fetch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t RUN    = 2'd1;
  localparam state_t HALTED = 2'd2;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'd0;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: load has priority over increment, otherwise hold.
// Increment wraps naturally at 2**ADDR_W.
module pc_reg #(
  parameter int              ADDR_W   = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // next PC selection
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives imem, registers the fetched word for decode
// with valid/ready, handles branch flush and halt. FETCH_CNT_EN adds fetch_count.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = 3,
  parameter int                 INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(RESET_PC_DEFAULT),
  parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(HALT_WORD_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               dec_ready,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               halted
`ifdef FETCH_CNT_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  state_t             state_q, state_d;
  logic               dec_valid_q, dec_valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               halted_q, halted_d;
  logic               pc_load_s, pc_inc_s;
  logic               advance_s;
  logic [ADDR_W-1:0]  pc_s;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (pc_load_s),
    .load_val_i (br_target),
    .inc_i      (pc_inc_s),
    .pc_o       (pc_s)
  );

  assign advance_s = !dec_valid_q || dec_ready;

  // FSM and pipeline-register next state; branch outranks stall/advance/halt
  always_comb begin
    state_d     = state_q;
    dec_valid_d = dec_valid_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    pc_load_s   = 1'b0;
    pc_inc_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (br_valid) begin
          pc_load_s = 1'b1;
        end else if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (br_valid) begin
          pc_load_s   = 1'b1;
          dec_valid_d = 1'b0;
        end else if (advance_s) begin
          instr_d     = imem_instr;
          pc_out_d    = pc_s;
          dec_valid_d = 1'b1;
          if (imem_instr == HALT_WORD) begin
            state_d = HALTED;
          end else begin
            pc_inc_s = 1'b1;
          end
        end else begin
          dec_valid_d = dec_valid_q;
        end
      end
      HALTED: begin
        if (br_valid) begin
          pc_load_s   = 1'b1;
          dec_valid_d = 1'b0;
          state_d     = RUN;
        end else if (dec_ready) begin
          dec_valid_d = 1'b0;
        end else begin
          dec_valid_d = dec_valid_q;
        end
      end
      default: begin
        state_d     = IDLE;
        dec_valid_d = 1'b0;
      end
    endcase
    halted_d = (state_d == HALTED);
  end

  // stage registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dec_valid_q <= 1'b0;
      instr_q     <= {INSTR_W{1'b0}};
      pc_out_q    <= {ADDR_W{1'b0}};
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_valid_q <= dec_valid_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_addr = pc_s;
  assign dec_valid = dec_valid_q;
  assign instr_out = instr_q;
  assign pc_out    = pc_out_q;
  assign halted    = halted_q;

`ifdef FETCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // saturating count of accepted transfers; a branch does not clear it
  always_comb begin
    if (dec_valid_q && dec_ready && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_count = cnt_q;
`else
  // no transfer counter in this build
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a behavioural model
// of the fetch stage (next-fetch address, held instruction, mode).
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] instr_out;
  logic [2:0]  pc_out;
  logic        br_valid;
  logic [2:0]  br_target;
  logic        halted;
`ifdef FETCH_CNT_EN
  logic [15:0] fetch_count;
`endif

  logic [31:0] mem [8];
  assign imem_instr = mem[imem_addr];

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .dec_ready  (dec_ready),
    .dec_valid  (dec_valid),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .halted     (halted)
`ifdef FETCH_CNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          m_mode = M_IDLE;
  int          m_pc   = 0;
  bit          m_v    = 1'b0;
  logic [31:0] m_instr = 32'd0;
  int          m_pco  = 0;
  int          m_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (!rst_n) begin
      m_mode = M_IDLE; m_pc = 0; m_v = 1'b0; m_instr = 32'd0; m_pco = 0; m_cnt = 0;
    end else begin
      if (m_v && dec_ready && m_cnt < 65535) m_cnt++;
      if (m_mode == M_IDLE) begin
        if (br_valid) m_pc = int'(br_target);
        else if (start) m_mode = M_RUN;
      end else if (br_valid) begin
        m_pc = int'(br_target); m_v = 1'b0; m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (!m_v || dec_ready) begin
          w = mem[m_pc];
          m_instr = w; m_pco = m_pc; m_v = 1'b1;
          if (w == HALT) m_mode = M_HALT;
          else m_pc = (m_pc + 1) % 8;
        end
      end else if (dec_ready) begin
        m_v = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("dec_valid", 32'(dec_valid), 32'(m_v));
    check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("instr_out", instr_out, m_instr);
    check("pc_out", 32'(pc_out), 32'(m_pco));
    check("halted", 32'(halted), 32'(m_mode == M_HALT));
`ifdef FETCH_CNT_EN
    check("fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'(i + 100);
    rst_n = 1'b0; start = 1'b0; dec_ready = 1'b0; br_valid = 1'b0; br_target = 3'd0;

    // reset
    tick(); tick();
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);

    // start, then first fetch
    rst_n = 1'b1; start = 1'b1; tick();
    start = 1'b0; dec_ready = 1'b1; tick();
    check("first_valid", 32'(dec_valid), 32'd1);
    check("first_instr", instr_out, 32'd100);
    check("first_pc", 32'(pc_out), 32'd0);

    // sequential fetch with wrap
    for (int i = 1; i < 10; i++) begin
      tick();
      check("seq_pc", 32'(pc_out), 32'(i % 8));
      check("seq_instr", instr_out, 32'(pc_out) + 32'd100);
    end
    tick(); tick();

    // stall on 103
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", instr_out, 32'd103);
      check("stall_pc", 32'(pc_out), 32'd3);
      check("stall_addr", 32'(imem_addr), 32'd4);
    end
    dec_ready = 1'b1; tick();
    check("unstall_instr", instr_out, 32'd104);

    // branch during stall
    dec_ready = 1'b0; br_valid = 1'b1; br_target = 3'd6; tick();
    check("br_flush", 32'(dec_valid), 32'd0);
    check("br_instr_kept", instr_out, 32'd104);
    br_valid = 1'b0; dec_ready = 1'b1; tick();
    check("br_instr", instr_out, 32'd106);
    check("br_pc", 32'(pc_out), 32'd6);

    // halt at word 5
    mem[5] = HALT;
    br_valid = 1'b1; br_target = 3'd4; tick();
    br_valid = 1'b0; tick(); tick();
    check("halt_instr", instr_out, HALT);
    check("halt_pc", 32'(pc_out), 32'd5);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_addr", 32'(imem_addr), 32'd5);
    dec_ready = 1'b0; tick();
    check("halt_hold", 32'(dec_valid), 32'd1);
    dec_ready = 1'b1; tick();
    check("halt_drain", 32'(dec_valid), 32'd0);
    check("halt_addr2", 32'(imem_addr), 32'd5);
    tick();
    br_valid = 1'b1; br_target = 3'd0; tick();
    check("unhalt_flag", 32'(halted), 32'd0);
    br_valid = 1'b0; tick();
    check("unhalt_instr", instr_out, 32'd100);

    // reset during stall
    dec_ready = 1'b0; tick();
    rst_n = 1'b0; tick();
    check("midrst_valid", 32'(dec_valid), 32'd0);
`ifdef FETCH_CNT_EN
    check("midrst_count", 32'(fetch_count), 32'd0);
`endif
    rst_n = 1'b1; dec_ready = 1'b1; tick();
    check("midrst_idle", 32'(dec_valid), 32'd0);
    mem[5] = 32'd105;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      start     = ($urandom_range(0, 3) == 0);
      dec_ready = ($urandom_range(0, 2) != 0);
      br_valid  = ($urandom_range(0, 9) == 0);
      br_target = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0)
        mem[$urandom_range(0, 7)] = ($urandom_range(0, 2) == 0) ? HALT : $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
